// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage and the thread-banked register file.
// This covers the thread-count derivation, the result-select encodings and the x0 index.
package wb_regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } result_src_e;

  function automatic int num_threads(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Bundle of the MEM/WB inputs, the decode read-port signals and the instret port.
// The pipeline drives through the master modport, and the register file uses slave.
interface wb_regfile_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BITS_THREADS  = 3
);

  logic                     valid_w_i;
  logic                     reg_write_w_i;
  logic [1:0]               result_src_w_i;
  logic [DATA_WIDTH-1:0]    alu_result_w_i;
  logic [DATA_WIDTH-1:0]    read_data_w_i;
  logic [4:0]               rd_w_i;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_w_i;
  logic [BITS_THREADS-1:0]  tid_w_i;
  logic [DATA_WIDTH-1:0]    result_w_o;

  logic [BITS_THREADS-1:0]  tid_d_i;
  logic [4:0]               rs1_d_i;
  logic [4:0]               rs2_d_i;
  logic [DATA_WIDTH-1:0]    rd1_d_o;
  logic [DATA_WIDTH-1:0]    rd2_d_o;

  logic [BITS_THREADS-1:0]  instret_sel_i;
  logic [31:0]              instret_o;

  modport master (
    output valid_w_i, reg_write_w_i, result_src_w_i, alu_result_w_i, read_data_w_i,
           rd_w_i, pc_plus4_w_i, tid_w_i, tid_d_i, rs1_d_i, rs2_d_i, instret_sel_i,
    input  result_w_o, rd1_d_o, rd2_d_o, instret_o
  );

  modport slave (
    input  valid_w_i, reg_write_w_i, result_src_w_i, alu_result_w_i, read_data_w_i,
           rd_w_i, pc_plus4_w_i, tid_w_i, tid_d_i, rs1_d_i, rs2_d_i, instret_sel_i,
    output result_w_o, rd1_d_o, rd2_d_o, instret_o
  );

endinterface

// File: rtl/wb_regfile_rf_bank_array.sv
// Per-thread register banks with one synchronous write port and two combinational reads.
// x0 is never stored and always reads as zero. A synchronous active-low clear empties all banks.
module rf_bank_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BITS_THREADS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [BITS_THREADS-1:0] wtid_i,
  input  logic [4:0]              waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [BITS_THREADS-1:0] rtid_i,
  input  logic [4:0]              raddr1_i,
  input  logic [4:0]              raddr2_i,
  output logic [DATA_WIDTH-1:0]   rdata1_o,
  output logic [DATA_WIDTH-1:0]   rdata2_o
);

  localparam int NUM_THREADS = num_threads(BITS_THREADS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_THREADS][NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          mem_q[t][r] <= '0;
        end
      end
    end else if (we_i && (waddr_i != REG_ZERO)) begin
      mem_q[wtid_i][waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == REG_ZERO) ? '0 : mem_q[rtid_i][raddr1_i];
  assign rdata2_o = (raddr2_i == REG_ZERO) ? '0 : mem_q[rtid_i][raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage that selects the result, writes it to the issuing thread's bank, and serves decode.
// Both read ports get same-thread write bypass. A per-thread retired-instruction counter is kept here.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BITS_THREADS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_regfile_if.slave bus
);

  localparam int NUM_THREADS = num_threads(BITS_THREADS);

  logic [DATA_WIDTH-1:0]         result_w;
  logic                          we;
  logic                          bypass1;
  logic                          bypass2;
  logic [DATA_WIDTH-1:0]         arr_rd1;
  logic [DATA_WIDTH-1:0]         arr_rd2;
  logic [NUM_THREADS-1:0][31:0]  instret_q;
  logic [NUM_THREADS-1:0][31:0]  instret_d;

  // The reserved encoding falls back to the ALU result.
  always_comb begin
    result_w = bus.alu_result_w_i;
    case (result_src_e'(bus.result_src_w_i))
      RES_MEM: result_w = bus.read_data_w_i;
      RES_PC4: result_w = DATA_WIDTH'(bus.pc_plus4_w_i);
      default: result_w = bus.alu_result_w_i;
    endcase
  end

  assign bus.result_w_o = result_w;
  assign we = bus.valid_w_i && bus.reg_write_w_i && (bus.rd_w_i != REG_ZERO);

  rf_bank_array #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BITS_THREADS (BITS_THREADS)
  ) u_banks (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we),
    .wtid_i   (bus.tid_w_i),
    .waddr_i  (bus.rd_w_i),
    .wdata_i  (result_w),
    .rtid_i   (bus.tid_d_i),
    .raddr1_i (bus.rs1_d_i),
    .raddr2_i (bus.rs2_d_i),
    .rdata1_o (arr_rd1),
    .rdata2_o (arr_rd2)
  );

  // Bypass is only taken when the reading thread is the writing thread.
  assign bypass1 = we && (bus.tid_w_i == bus.tid_d_i) && (bus.rd_w_i == bus.rs1_d_i);
  assign bypass2 = we && (bus.tid_w_i == bus.tid_d_i) && (bus.rd_w_i == bus.rs2_d_i);

  assign bus.rd1_d_o = (bus.rs1_d_i == REG_ZERO) ? '0 : (bypass1 ? result_w : arr_rd1);
  assign bus.rd2_d_o = (bus.rs2_d_i == REG_ZERO) ? '0 : (bypass2 ? result_w : arr_rd2);

  // Every valid instruction retires, including stores and branches that never write rd.
  always_comb begin
    instret_d = instret_q;
    if (bus.valid_w_i) begin
      instret_d[bus.tid_w_i] = instret_q[bus.tid_w_i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret_o = instret_q[bus.instret_sel_i];

endmodule
